// File: rtl/or_and_bist.sv
// ============================================================================
// Module      : or_and_bist
// Description : Exhaustive 3-input BIST sequencer. It drives vectors 000..111,
//               samples E after a settle window, and tracks mismatch results.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module or_and_bist #(
  parameter logic [7:0] EXP_TABLE = 8'b1010_1000,
  parameter int         SETTLE    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       e,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_cnt,
  output logic       fail_seen,
  output logic [2:0] fail_vec
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_APPLY  = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [3:0] c_last_cnt = 4'(SETTLE - 1);
  localparam logic [2:0] c_last_vec = 3'd7;
  localparam logic [3:0] c_max_err  = 4'd8;

  state_t     r_state;
  state_t     w_state_next;
  logic [2:0] r_vec;
  logic [3:0] r_cnt;
  logic [3:0] r_err_cnt;
  logic       r_fail_seen;
  logic [2:0] r_fail_vec;
  logic       w_start_run;
  logic       w_sample;
  logic       w_mismatch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_start_run  = 1'b0;
    w_sample     = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_state_next = S_APPLY;
          w_start_run  = 1'b1;
        end
      end
      S_APPLY: begin
        if (r_cnt == c_last_cnt) begin
          w_state_next = S_SAMPLE;
        end
      end
      S_SAMPLE: begin
        w_sample     = 1'b1;
        w_state_next = (r_vec == c_last_vec) ? S_DONE : S_APPLY;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign w_mismatch = w_sample && (e != EXP_TABLE[r_vec]);

  // The vector register directly drives A/B/C, so it stays at 111 in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vec       <= 3'd0;
      r_cnt       <= 4'd0;
      r_err_cnt   <= 4'd0;
      r_fail_seen <= 1'b0;
      r_fail_vec  <= 3'd0;
    end else if (w_start_run) begin
      r_vec       <= 3'd0;
      r_cnt       <= 4'd0;
      r_err_cnt   <= 4'd0;
      r_fail_seen <= 1'b0;
      r_fail_vec  <= 3'd0;
    end else if (r_state == S_APPLY) begin
      if (r_cnt != c_last_cnt) begin
        r_cnt <= r_cnt + 4'd1;
      end
    end else if (r_state == S_SAMPLE) begin
      r_cnt <= 4'd0;
      if (r_vec != c_last_vec) begin
        r_vec <= r_vec + 3'd1;
      end
      if (w_mismatch) begin
        if (r_err_cnt != c_max_err) begin
          r_err_cnt <= r_err_cnt + 4'd1;
        end
        if (!r_fail_seen) begin
          r_fail_seen <= 1'b1;
          r_fail_vec  <= r_vec;
        end
      end
    end
  end

  assign a         = r_vec[2];
  assign b         = r_vec[1];
  assign c         = r_vec[0];
  assign busy      = (r_state == S_APPLY) || (r_state == S_SAMPLE);
  assign done      = (r_state == S_DONE);
  assign pass      = done && (r_err_cnt == 4'd0);
  assign err_cnt   = r_err_cnt;
  assign fail_seen = r_fail_seen;
  assign fail_vec  = r_fail_vec;

endmodule

`default_nettype wire

// File: tb/tb_or_and_bist.sv
// ============================================================================
// Module      : tb_or_and_bist
// Description : Self-checking bench for or_and_bist with a trace scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_or_and_bist;

  localparam int SETTLE = 4;
  localparam int RUN_LEN = 8 * (SETTLE + 1);

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       e;
  logic       a, b, c;
  logic       busy, done, pass;
  logic [3:0] err_cnt;
  logic       fail_seen;
  logic [2:0] fail_vec;

  int checks   = 0;
  int failures = 0;
  int mode     = 0;

  typedef struct {
    int         mode;
    logic       repulse;
    logic [3:0] err;
    logic       fs;
    logic [2:0] fv;
    logic       pass;
  } case_t;

  // Trace entries: {busy, done, a, b, c}
  logic [4:0] sb[$];

  or_and_bist #(
    .EXP_TABLE(8'b1010_1000),
    .SETTLE   (SETTLE)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .e        (e),
    .a        (a),
    .b        (b),
    .c        (c),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .err_cnt  (err_cnt),
    .fail_seen(fail_seen),
    .fail_vec (fail_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Response source: good loopback, stuck-at-0, stuck-at-1, or inverted.
  always_comb begin
    e = 1'b0;
    case (mode)
      0: e = (a | b) & c;
      1: e = 1'b0;
      2: e = 1'b1;
      default: e = ~((a | b) & c);
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_out"}, {a, b, c, busy, done, pass, err_cnt, fail_seen, fail_vec}, 32'd0);
  endtask

  task automatic run_case(input case_t cs);
    int i;
    logic [4:0] exp;
    mode = cs.mode;
    @(negedge clk);
    start = 1'b1;
    for (int k = 0; k < RUN_LEN; k++) sb.push_back({1'b1, 1'b0, 3'(k / (SETTLE + 1))});
    sb.push_back({1'b0, 1'b1, 3'b111});
    @(negedge clk);
    start = 1'b0;
    chk("start_clears", {28'd0, err_cnt}, 32'd0);
    chk("start_clears_fs", {31'd0, fail_seen}, 32'd0);
    i = 0;
    while (sb.size() > 0) begin
      exp = sb.pop_front();
      chk($sformatf("trace_%0d", i), {27'd0, busy, done, a, b, c}, {27'd0, exp});
      start = (cs.repulse && i == 10);
      i++;
      if (sb.size() > 0) @(negedge clk);
    end
    start = 1'b0;
    chk("err_cnt", {28'd0, err_cnt}, {28'd0, cs.err});
    chk("fail_seen", {31'd0, fail_seen}, {31'd0, cs.fs});
    if (cs.fs) chk("fail_vec", {29'd0, fail_vec}, {29'd0, cs.fv});
    chk("pass", {31'd0, pass}, {31'd0, cs.pass});
    repeat (2) @(negedge clk);
    chk("done_hold", {26'd0, done, busy, a, b, c, pass},
        {26'd0, 1'b1, 1'b0, 3'b111, cs.pass});
    chk("done_hold_err", {28'd0, err_cnt}, {28'd0, cs.err});
  endtask

  case_t cases[5];

  initial begin
    cases[0] = '{0, 1'b0, 4'd0, 1'b0, 3'd0, 1'b1};
    cases[1] = '{1, 1'b0, 4'd3, 1'b1, 3'd3, 1'b0};
    cases[2] = '{2, 1'b1, 4'd5, 1'b1, 3'd0, 1'b0};
    cases[3] = '{3, 1'b0, 4'd8, 1'b1, 3'd0, 1'b0};
    cases[4] = '{0, 1'b1, 4'd0, 1'b0, 3'd0, 1'b1};

    rst_n = 1'b0;
    start = 1'b0;
    #1;
    chk_all_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_after_release", {29'd0, busy, done, a | b | c}, 32'd0);

    // Back-to-back runs also exercise restart from DONE.
    for (int n = 0; n < 5; n++) run_case(cases[n]);

    // Asynchronous reset part-way through a failing run.
    mode = 1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    chk("mid_run_busy", {31'd0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk_all_zero("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk_all_zero("post_reset_idle");
    run_case(cases[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
